tan_unit_arbiter: RTL

- Shares one tan series unit between two requesters and sequences its start/ready handshake.
- Registers each requester's operand, drives the unit's level-sensitive start (high then low), and waits for busy and then ready.
- Captures the result into a per-requester result register and pulses a completion strobe.
- Sits between the client blocks and the tan controller/datapath pair; provides timeout detection if the unit never responds.

---
 rtl/tan_unit_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tan_unit_arbiter.sv
// Two-requester front end for a shared tan series unit: round-robin arbitration,
// start/busy/ready handshake sequencing, per-requester result registers, timeout abort.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | no service in flight; arbitrate req0/req1, latch operand
// S_START     | tan_start high for this single cycle
// S_WAIT_BUSY | start released; waiting for the unit to raise busy
// S_WAIT_DONE | unit computing; waiting for busy low with ready high
// S_CAPTURE   | done (and err on abort) strobe cycle; rr pointer updated
module tan_unit_arbiter #(
  parameter int W       = 16,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] x0,
  input  logic         req1,
  input  logic [W-1:0] x1,
  output logic         grant0,
  output logic         grant1,
  output logic         done0,
  output logic         done1,
  output logic         err,
  output logic [W-1:0] res0,
  output logic [W-1:0] res1,
  output logic         tan_start,
  output logic [W-1:0] tan_x,
  input  logic         tan_busy,
  input  logic         tan_ready,
  input  logic [W-1:0] tan_result
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE
  } state_t;

  state_t       state_q, state_d;
  logic         win_q, win_d;
  logic         rr_q, rr_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [1:0]   grant_q, grant_d;
  logic [1:0]   done_q, done_d;
  logic         err_q, err_d;
  logic         start_q, start_d;
  logic [W-1:0] tan_x_q, tan_x_d;
  logic [W-1:0] res0_q, res0_d;
  logic [W-1:0] res1_q, res1_d;
  logic         win_sel;
  logic         timed_out;

  always_comb begin
    // On a tie the requester that was not served last wins.
    win_sel   = (req0 && req1) ? ~rr_q : req1;
    timed_out = (cnt_q == CNT_LAST);

    state_d = state_q;
    win_d   = win_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = 2'b00;
    err_d   = 1'b0;
    start_d = 1'b0;
    tan_x_d = tan_x_q;
    res0_d  = res0_q;
    res1_d  = res1_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          win_d   = win_sel;
          tan_x_d = win_sel ? x1 : x0;
          grant_d = win_sel ? 2'b10 : 2'b01;
          start_d = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end

      // ready while idle is expected here and deliberately ignored
      S_WAIT_BUSY: begin
        if (tan_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (timed_out) begin
          done_d[win_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_WAIT_DONE: begin
        if (!tan_busy && tan_ready) begin
          done_d[win_q] = 1'b1;
          if (win_q) res1_d = tan_result;
          else       res0_d = tan_result;
          state_d = S_CAPTURE;
        end else if (timed_out) begin
          done_d[win_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_CAPTURE: begin
        rr_d    = win_q;
        grant_d = 2'b00;
        tan_x_d = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        grant_d = 2'b00;
        tan_x_d = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      rr_q    <= 1'b1;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      tan_x_q <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      tan_x_q <= tan_x_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

  assign grant0    = grant_q[0];
  assign grant1    = grant_q[1];
  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign err       = err_q;
  assign res0      = res0_q;
  assign res1      = res1_q;
  assign tan_start = start_q;
  assign tan_x     = tan_x_q;

endmodule
